// File: rtl/hb_pkg.sv
// Shared types and reset defaults for the heartbeat rate sequencer.
package hb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } hb_state_t;

  localparam int DEF_THRESHOLD = 1;
  localparam int DEF_REPEATS   = 1;

endpackage

// File: rtl/hb_tick_divider.sv
// Programmable half-period divider: toggles div_out every threshold cycles
// while run is high and decodes one beat per full output period.
module hb_tick_divider
  import hb_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [CNT_W-1:0] threshold,
  output logic             div_out,
  output logic             beat
);

  logic [CNT_W-1:0] cnt;
  logic             at_top;

  // threshold is never zero here; the sequencer saturates it to 1 on load
  assign at_top = (cnt == (threshold - CNT_W'(1)));
  assign beat   = run && at_top && div_out;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt     <= '0;
      div_out <= 1'b0;
    end else if (run) begin
      if (at_top) begin
        cnt     <= '0;
        div_out <= ~div_out;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/hb_rate_sequencer.sv
// Steps a single heartbeat divider through a table of rate phases, changing
// rate only on beat boundaries; runs the table once or loops it.
module hb_rate_sequencer
  import hb_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 32,
  parameter int REP_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          loop,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_PHASES)-1:0] cfg_idx,
  input  logic [CNT_W-1:0]              cfg_threshold,
  input  logic [REP_W-1:0]              cfg_repeats,
  output logic                          div_out,
  output logic                          beat,
  output logic [$clog2(NUM_PHASES)-1:0] phase,
  output logic                          busy,
  output logic                          done
);

  localparam int IDX_W = $clog2(NUM_PHASES);
  localparam logic [IDX_W-1:0] LAST_PHASE = IDX_W'(NUM_PHASES - 1);

  hb_state_t        state_q, state_d;
  logic [IDX_W-1:0] phase_d;

  logic [CNT_W-1:0] thr_tab [NUM_PHASES];
  logic [REP_W-1:0] rep_tab [NUM_PHASES];
  logic [CNT_W-1:0] thr_act;
  logic [REP_W-1:0] rep_act;
  logic [REP_W-1:0] beat_cnt, beat_cnt_inc;
  logic             run, clr, phase_end;

  assign run = (state_q == RUN);
  assign clr = reset || stop || !run;

  hb_tick_divider #(
    .CNT_W(CNT_W)
  ) u_div (
    .clk      (clk),
    .clr      (clr),
    .run      (run),
    .threshold(thr_act),
    .div_out  (div_out),
    .beat     (beat)
  );

  // Table writes never disturb the active phase; they are picked up at LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PHASES; i++) begin
        thr_tab[i] <= CNT_W'(DEF_THRESHOLD);
        rep_tab[i] <= REP_W'(DEF_REPEATS);
      end
    end else if (cfg_we && (32'(cfg_idx) < NUM_PHASES)) begin
      thr_tab[cfg_idx] <= cfg_threshold;
      rep_tab[cfg_idx] <= cfg_repeats;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      thr_act <= CNT_W'(DEF_THRESHOLD);
      rep_act <= REP_W'(DEF_REPEATS);
    end else if (state_q == LOAD) begin
      thr_act <= (thr_tab[phase] == '0) ? CNT_W'(1) : thr_tab[phase];
      rep_act <= (rep_tab[phase] == '0) ? REP_W'(1) : rep_tab[phase];
    end
  end

  // Beat counter saturates instead of wrapping.
  assign beat_cnt_inc = (beat_cnt == '1) ? beat_cnt : beat_cnt + REP_W'(1);
  assign phase_end    = beat && (beat_cnt_inc >= rep_act);

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      beat_cnt <= '0;
    end else if (beat) begin
      beat_cnt <= beat_cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase   <= '0;
    end else begin
      state_q <= state_d;
      phase   <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          phase_d = '0;
        end
      end
      LOAD: begin
        busy    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (phase_end) begin
          if (phase != LAST_PHASE) begin
            phase_d = phase + IDX_W'(1);
            state_d = LOAD;
          end else if (loop) begin
            phase_d = '0;
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // stop overrides everything, including a same-cycle start
    if (stop) begin
      state_d = IDLE;
      phase_d = phase;
    end
  end

endmodule

// File: tb/tb_hb_rate_sequencer.sv
// Directed bench for hb_rate_sequencer: cycle-by-cycle traces checked against
// hand-computed beat/done/phase timing.
module tb_hb_rate_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        loop;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_threshold;
  logic [7:0]  cfg_repeats;
  logic        div_out;
  logic        beat;
  logic [1:0]  phase;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  int beatT  [64];
  int doneT  [64];
  int busyT  [64];
  int divT   [64];
  int phaseT [64];

  hb_rate_sequencer #(
    .NUM_PHASES(4),
    .CNT_W     (32),
    .REP_W     (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .loop         (loop),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_threshold(cfg_threshold),
    .cfg_repeats  (cfg_repeats),
    .div_out      (div_out),
    .beat         (beat),
    .phase        (phase),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic writeEntry(input logic [1:0] idx, input logic [31:0] t,
                            input logic [7:0] r);
    cfg_we        = 1'b1;
    cfg_idx       = idx;
    cfg_threshold = t;
    cfg_repeats   = r;
    stepCycle();
    cfg_we = 1'b0;
  endtask

  // Pulses start in cycle 0 and records outputs for cycles 1..nCycles.
  task automatic applyStimulus(input int nCycles, input int loopOffAt,
                               input int writeAt, input logic [1:0] wIdx,
                               input logic [31:0] wT, input logic [7:0] wR);
    for (int i = 0; i < 64; i++) begin
      beatT[i] = 0; doneT[i] = 0; busyT[i] = 0; divT[i] = 0; phaseT[i] = 0;
    end
    start = 1'b1;
    for (int c = 1; c <= nCycles; c++) begin
      stepCycle();
      start     = 1'b0;
      cfg_we    = 1'b0;
      beatT[c]  = int'(beat);
      doneT[c]  = int'(done);
      busyT[c]  = int'(busy);
      divT[c]   = int'(div_out);
      phaseT[c] = int'(phase);
      if (c == loopOffAt) loop = 1'b0;
      if (c == writeAt) begin
        cfg_we        = 1'b1;
        cfg_idx       = wIdx;
        cfg_threshold = wT;
        cfg_repeats   = wR;
      end
    end
  endtask

  function automatic int countOnes(input int first, input int last, input bit useDone);
    int n = 0;
    for (int c = first; c <= last; c++) n += useDone ? doneT[c] : beatT[c];
    return n;
  endfunction

  initial begin
    int dn;
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_threshold = '0; cfg_repeats = '0;
    repeat (3) stepCycle();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_phase", phase, 0);
    checkOutput("rst_div", div_out, 0);
    checkOutput("rst_beat", beat, 0);
    reset = 1'b0;
    stepCycle();

    $display("[TB] default table, single pass");
    applyStimulus(16, -1, -1, 2'd0, 32'd0, 8'd0);
    checkOutput("def_load_div", divT[1], 0);
    checkOutput("def_load_busy", busyT[1], 1);
    checkOutput("def_beat3", beatT[3], 1);
    checkOutput("def_beat6", beatT[6], 1);
    checkOutput("def_beat9", beatT[9], 1);
    checkOutput("def_beat12", beatT[12], 1);
    checkOutput("def_beat_count", countOnes(1, 16, 1'b0), 4);
    checkOutput("def_phase3", phaseT[3], 0);
    checkOutput("def_phase6", phaseT[6], 1);
    checkOutput("def_phase9", phaseT[9], 2);
    checkOutput("def_phase12", phaseT[12], 3);
    checkOutput("def_done13", doneT[13], 1);
    checkOutput("def_done_count", countOnes(1, 16, 1'b1), 1);
    checkOutput("def_busy13", busyT[13], 0);
    checkOutput("def_phase_hold", phaseT[15], 3);

    $display("[TB] loop mode, then drop loop");
    loop = 1'b1;
    applyStimulus(30, 14, -1, 2'd0, 32'd0, 8'd0);
    checkOutput("loop_no_done", countOnes(1, 24, 1'b1), 0);
    checkOutput("loop_phase13", phaseT[13], 0);
    checkOutput("loop_busy13", busyT[13], 1);
    checkOutput("loop_beat15", beatT[15], 1);
    checkOutput("loop_done25", doneT[25], 1);
    checkOutput("loop_idle26", busyT[26], 0);

    $display("[TB] stop with simultaneous start");
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      stepCycle();
      start = 1'b0;
    end
    checkOutput("stop_pre_phase", phase, 2);
    checkOutput("stop_pre_busy", busy, 1);
    stop = 1'b1; start = 1'b1;
    stepCycle();
    stop = 1'b0; start = 1'b0;
    checkOutput("stop_busy", busy, 0);
    checkOutput("stop_div", div_out, 0);
    checkOutput("stop_done", done, 0);
    dn = 0;
    for (int c = 0; c < 5; c++) begin
      stepCycle();
      dn += int'(done) + int'(busy);
    end
    checkOutput("stop_stays_idle", dn, 0);
    applyStimulus(16, -1, -1, 2'd0, 32'd0, 8'd0);
    checkOutput("restart_phase1", phaseT[1], 0);
    checkOutput("restart_phase4", phaseT[4], 1);
    checkOutput("restart_done13", doneT[13], 1);

    $display("[TB] mixed table");
    writeEntry(2'd0, 32'd3, 8'd2);
    writeEntry(2'd1, 32'd1, 8'd1);
    writeEntry(2'd2, 32'd5, 8'd1);
    writeEntry(2'd3, 32'd2, 8'd3);
    applyStimulus(45, -1, -1, 2'd0, 32'd0, 8'd0);
    checkOutput("mix_div4", divT[4], 0);
    checkOutput("mix_div5", divT[5], 1);
    checkOutput("mix_beat7", beatT[7], 1);
    checkOutput("mix_beat13", beatT[13], 1);
    checkOutput("mix_phase13", phaseT[13], 0);
    checkOutput("mix_phase14", phaseT[14], 1);
    checkOutput("mix_load_div14", divT[14], 0);
    checkOutput("mix_beat16", beatT[16], 1);
    checkOutput("mix_beat27", beatT[27], 1);
    checkOutput("mix_beat32", beatT[32], 1);
    checkOutput("mix_beat36", beatT[36], 1);
    checkOutput("mix_beat40", beatT[40], 1);
    checkOutput("mix_beat_count", countOnes(1, 45, 1'b0), 7);
    checkOutput("mix_done40", doneT[40], 0);
    checkOutput("mix_done41", doneT[41], 1);

    $display("[TB] zero threshold and repeats saturate to one");
    writeEntry(2'd0, 32'd2, 8'd1);
    writeEntry(2'd1, 32'd0, 8'd0);
    writeEntry(2'd2, 32'd1, 8'd1);
    writeEntry(2'd3, 32'd1, 8'd1);
    applyStimulus(20, -1, -1, 2'd0, 32'd0, 8'd0);
    checkOutput("zero_beat5", beatT[5], 1);
    checkOutput("zero_phase6", phaseT[6], 1);
    checkOutput("zero_beat8", beatT[8], 1);
    checkOutput("zero_done15", doneT[15], 1);

    $display("[TB] rewrite active entry during loop");
    writeEntry(2'd0, 32'd2, 8'd2);
    writeEntry(2'd1, 32'd1, 8'd1);
    loop = 1'b1;
    applyStimulus(34, 20, 3, 2'd0, 32'd1, 8'd1);
    checkOutput("rw_beat5", beatT[5], 1);
    checkOutput("rw_beat7", beatT[7], 0);
    checkOutput("rw_beat9", beatT[9], 1);
    checkOutput("rw_phase10", phaseT[10], 1);
    checkOutput("rw_phase19", phaseT[19], 0);
    checkOutput("rw_beat21", beatT[21], 1);
    checkOutput("rw_done31", doneT[31], 1);

    $display("[TB] reset restores table defaults");
    writeEntry(2'd2, 32'd4, 8'd2);
    reset = 1'b1;
    repeat (2) stepCycle();
    reset = 1'b0;
    stepCycle();
    applyStimulus(16, -1, -1, 2'd0, 32'd0, 8'd0);
    checkOutput("rst_tab_beat9", beatT[9], 1);
    checkOutput("rst_tab_done13", doneT[13], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
